pe_multicast_ctrl: RTL and testbench

- Per-PE multicast controller (MC) sitting directly upstream of a PE's ifmap/filter/ipsum input port on the global input network (GIN) bus.
- Holds a configured ID and compares it with the tag travelling with each bus word. On a match (or broadcast tag) it buffers the word in a small FIFO and delivers it to the PE over the enable/ready handshake; on a mismatch it silently consumes the word.
- Non-matching MCs never stall the bus, so the bus-level ready is the AND of all MC in_ready signals.

---
 rtl/pe_array_pkg.sv | 19 +
 rtl/pe_multicast_ctrl_if.sv | 31 +++
 rtl/pe_mc_fifo.sv | 60 ++++++
 rtl/pe_multicast_ctrl.sv | 63 ++++++
 tb/tb_pe_multicast_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_array_pkg.sv
// Shared PE-array definitions: tag/ID sizing, the broadcast tag and bus word sizing helpers.
package pe_array_pkg;

    localparam int PE_ID_SIZE    = 5;
    localparam int PE_DATA_SIZE  = 8;
    localparam int PE_DATA_NUM   = 1;
    localparam int PE_FIFO_DEPTH = 2;

    // All ones at any ID width; consumers slice the low ID_SIZE bits.
    localparam logic [31:0] BROADCAST_TAG = '1;

    typedef logic [PE_ID_SIZE-1:0]                pe_id_t;
    typedef logic [PE_DATA_NUM*PE_DATA_SIZE-1:0]  pe_word_t;

    function automatic int bus_word_w(input int data_size, input int data_num);
        return data_size * data_num;
    endfunction

endpackage

// File: rtl/pe_multicast_ctrl_if.sv
// GIN bus side (tag/valid/data/ready) and PE side (enable/data/ready) of one multicast controller.
interface pe_multicast_ctrl_if
    import pe_array_pkg::*;
#(
    parameter int DATA_SIZE = PE_DATA_SIZE,
    parameter int DATA_NUM  = PE_DATA_NUM,
    parameter int ID_SIZE   = PE_ID_SIZE
);

    localparam int WORD_W = bus_word_w(DATA_SIZE, DATA_NUM);

    logic [ID_SIZE-1:0] tag;
    logic               in_valid;
    logic [WORD_W-1:0]  in_data;
    logic               in_ready;
    logic               out_enable;
    logic [WORD_W-1:0]  out_data;
    logic               out_ready;

    // master: the bus source plus the PE; slave: the multicast controller.
    modport master (
        output tag, in_valid, in_data, out_ready,
        input  in_ready, out_enable, out_data
    );

    modport slave (
        input  tag, in_valid, in_data, out_ready,
        output in_ready, out_enable, out_data
    );

endinterface

// File: rtl/pe_mc_fifo.sv
// Small synchronous FIFO with zero-latency head read; full/empty come from the entry count.
module pe_mc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets both pointers wrap on plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign count = cnt;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/pe_multicast_ctrl.sv
// Per-PE multicast controller: filters GIN words by tag against the configured ID and buffers matches for the PE.
module pe_multicast_ctrl
    import pe_array_pkg::*;
#(
    parameter int DATA_SIZE  = PE_DATA_SIZE,
    parameter int DATA_NUM   = PE_DATA_NUM,
    parameter int ID_SIZE    = PE_ID_SIZE,
    parameter int FIFO_DEPTH = PE_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_id,
    input  logic [ID_SIZE-1:0]            id_in,
    pe_multicast_ctrl_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [ID_SIZE-1:0]            id_q
);

    localparam int                 WORD_W = bus_word_w(DATA_SIZE, DATA_NUM);
    localparam logic [ID_SIZE-1:0] BCAST  = BROADCAST_TAG[ID_SIZE-1:0];

    logic match;
    logic full;
    logic empty;
    logic push;
    logic pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q <= '0;
        end else if (set_id) begin
            id_q <= id_in;
        end
    end

    // Uses the ID held before any same-cycle reconfiguration.
    assign match = (bus.tag == id_q) || (bus.tag == BCAST);

    // Mismatching words are always swallowed so this MC never stalls other PEs;
    // deliberately no path from out_ready, so a full FIFO stalls even in a pop cycle.
    assign bus.in_ready = !set_id && (!match || !full);

    assign push = bus.in_valid && bus.in_ready && match;
    assign pop  = !empty && bus.out_ready;

    pe_mc_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .full  (full),
        .empty (empty),
        .count (occupancy),
        .head  (bus.out_data)
    );

    assign bus.out_enable = !empty;

endmodule

// File: tb/tb_pe_multicast_ctrl.sv
// Directed bench for pe_multicast_ctrl with a queue-based reference model checked every cycle.
module tb_pe_multicast_ctrl;

    localparam int DS    = 8;
    localparam int DN    = 1;
    localparam int IDS   = 5;
    localparam int DEPTH = 2;
    localparam int W     = DS * DN;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      set_id = 1'b0;
    logic [IDS-1:0]            id_in = '0;
    logic [$clog2(DEPTH):0]    occupancy;
    logic [IDS-1:0]            id_q;

    pe_multicast_ctrl_if #(.DATA_SIZE(DS), .DATA_NUM(DN), .ID_SIZE(IDS)) bus ();

    pe_multicast_ctrl #(
        .DATA_SIZE  (DS),
        .DATA_NUM   (DN),
        .ID_SIZE    (IDS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_id    (set_id),
        .id_in     (id_in),
        .bus       (bus),
        .occupancy (occupancy),
        .id_q      (id_q)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: configured ID plus a plain queue of buffered words.
    logic [IDS-1:0] m_id = '0;
    logic [W-1:0]   mq[$];
    logic [W-1:0]   got[$];

    function automatic bit m_match(input logic [IDS-1:0] t);
        return (t == m_id) || (t == 5'd31);
    endfunction

    function automatic bit m_ready();
        return !set_id && (!m_match(bus.tag) || (mq.size() < DEPTH));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_id = '0;
            mq.delete();
        end else begin
            bit rdy;
            bit mt;
            rdy = m_ready();
            mt  = m_match(bus.tag);
            if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
            if (bus.in_valid && rdy && mt) mq.push_back(bus.in_data);
            if (set_id) m_id = id_in;
        end
    end

    always @(negedge clk) begin
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready()});
        check("out_enable", {31'd0, bus.out_enable}, (mq.size() > 0) ? 32'd1 : 32'd0);
        if (mq.size() > 0) check("out_data", 32'(bus.out_data), 32'(mq[0]));
        check("occupancy", 32'(occupancy), mq.size());
        check("id_q", 32'(id_q), 32'(m_id));
        if (bus.out_enable && bus.out_ready && !rst) got.push_back(bus.out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sid, input logic [IDS-1:0] idv, input logic [IDS-1:0] tg,
                         input bit v, input logic [W-1:0] d, input bit ordy);
        set_id        = sid;
        id_in         = idv;
        bus.tag       = tg;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #2;
    endtask

    task automatic expect_pop(input string name, input logic [W-1:0] exp);
        if (got.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_delivery required=%0h", name, exp);
        end else begin
            check(name, 32'(got.pop_front()), 32'(exp));
        end
    endtask

    task automatic expect_none(input string name);
        check(name, got.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tag       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_out_enable", {31'd0, bus.out_enable}, 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_id_q", 32'(id_q), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        tick();
        rst = 1'b0;

        // Configure ID 5 and deliver one matching word.
        drive(1, 5, 0, 0, 8'h00, 1);
        check("t1_in_ready_setid", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("t1_id_q", 32'(id_q), 32'd5);
        drive(0, 0, 5, 1, 8'h2A, 1);
        check("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 1);
        check("t1_out_enable", {31'd0, bus.out_enable}, 32'd1);
        check("t1_out_data", 32'(bus.out_data), 32'h2A);
        tick();
        check("t1_occ_after", 32'(occupancy), 32'd0);
        expect_pop("t1_word", 8'h2A);
        expect_none("t1_extra");

        // Mismatch is consumed silently; broadcast is delivered.
        drive(0, 0, 7, 1, 8'h11, 1);
        check("t2_in_ready_mismatch", {31'd0, bus.in_ready}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 1);
        check("t2_out_enable", {31'd0, bus.out_enable}, 32'd0);
        check("t2_occupancy", 32'(occupancy), 32'd0);
        tick();
        drive(0, 0, 31, 1, 8'h33, 1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 1);
        tick();
        expect_pop("t2_bcast", 8'h33);
        expect_none("t2_extra");

        // Fill, stall matching words, keep consuming mismatches, then drain in order.
        drive(0, 0, 5, 1, 8'h01, 0);
        tick();
        drive(0, 0, 5, 1, 8'h02, 0);
        tick();
        drive(0, 0, 5, 1, 8'h03, 0);
        check("t3_occ_full", 32'(occupancy), 32'd2);
        check("t3_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
        tick();
        drive(0, 0, 7, 1, 8'h99, 0);
        check("t3_in_ready_mismatch_full", {31'd0, bus.in_ready}, 32'd1);
        tick();
        drive(0, 0, 5, 1, 8'h03, 1);
        check("t4_in_ready_pop_cycle", {31'd0, bus.in_ready}, 32'd0);
        tick();
        drive(0, 0, 5, 1, 8'h03, 1);
        check("t4_in_ready_next", {31'd0, bus.in_ready}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 1);
        tick();
        expect_pop("t3_w1", 8'h01);
        expect_pop("t3_w2", 8'h02);
        expect_pop("t3_w3", 8'h03);
        expect_none("t3_extra");

        // Sustained throughput.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 5, 1, 8'(8'h10 + i), 1);
            check("t4_stream_ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
        end
        drive(0, 0, 0, 0, 8'h00, 1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 1);
        tick();
        for (int i = 0; i < 16; i++) expect_pop("t4_stream", 8'(8'h10 + i));
        expect_none("t4_extra");

        // ID change keeps buffered data, then filters on the new ID.
        drive(0, 0, 5, 1, 8'h44, 0);
        tick();
        drive(1, 9, 5, 1, 8'h45, 0);
        check("t5_in_ready_setid", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("t5_id_q", 32'(id_q), 32'd9);
        drive(0, 0, 5, 1, 8'h46, 0);
        check("t5_in_ready_oldid", {31'd0, bus.in_ready}, 32'd1);
        tick();
        drive(0, 0, 9, 1, 8'h47, 1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 1);
        tick();
        expect_pop("t5_buffered", 8'h44);
        expect_pop("t5_newid", 8'h47);
        expect_none("t5_extra");

        // Asynchronous reset with a full FIFO.
        drive(0, 0, 9, 1, 8'h60, 0);
        tick();
        drive(0, 0, 9, 1, 8'h61, 0);
        tick();
        drive(0, 0, 0, 0, 8'h00, 0);
        check("t6_occ_before", 32'(occupancy), 32'd2);
        rst = 1'b1;
        #1;
        check("t6_out_enable", {31'd0, bus.out_enable}, 32'd0);
        check("t6_occupancy", 32'(occupancy), 32'd0);
        check("t6_id_q", 32'(id_q), 32'd0);
        check("t6_out_data", 32'(bus.out_data), 32'd0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00, 1);
        check("t6_no_delivery", {31'd0, bus.out_enable}, 32'd0);
        tick();
        drive(0, 0, 0, 1, 8'h55, 1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 1);
        tick();
        expect_pop("t6_after_reset", 8'h55);
        expect_none("t6_extra");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
